reg_wb_ctrl: RTL

// - Write-side initiator for the 8x8 register file; drives its write_reg/dest_reg/dest_reg_data and read_strobe/dest_reg_data2 ports.
// - Arbitrates two writeback sources, ALU results and load/IN-port results, onto one registered write command per cycle.
// - Buffers load results in a small FIFO and exports a pending-write mask so issue logic can detect RAW/WAW hazards.

---
 rtl/reg_wb_ctrl_pkg.sv | 22 ++
 rtl/reg_wb_ctrl_if.sv | 34 +++
 rtl/reg_wb_ctrl_wb_fifo.sv | 77 +++++++
 rtl/reg_wb_ctrl.sv | 111 +++++++++++
 4 files changed

// File: rtl/reg_wb_ctrl_pkg.sv
// Shared widths, writeback source encoding and register-index decode for the
// register-file write-side controller.
package reg_wb_ctrl_pkg;

    localparam int REG_W     = 8;
    localparam int REG_IDX_W = 3;
    localparam int NUM_REGS  = 8;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_LD   = 2'd2
    } wb_src_t;

    function automatic logic [NUM_REGS-1:0] dec_reg(input logic [REG_IDX_W-1:0] idx);
        logic [NUM_REGS-1:0] m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/reg_wb_ctrl_if.sv
// Writeback sources (ALU, load) on one side, register-file write port and
// hazard status on the other.
interface reg_wb_ctrl_if;
    import reg_wb_ctrl_pkg::*;

    logic                 alu_valid;
    logic                 alu_ready;
    logic [REG_IDX_W-1:0] alu_dest;
    logic [REG_W-1:0]     alu_data;
    logic                 ld_valid;
    logic                 ld_ready;
    logic [REG_IDX_W-1:0] ld_dest;
    logic [REG_W-1:0]     ld_data;
    logic                 write_reg;
    logic                 read_strobe;
    logic [REG_IDX_W-1:0] dest_reg;
    logic [REG_W-1:0]     dest_reg_data;
    logic [REG_W-1:0]     dest_reg_data2;
    logic [NUM_REGS-1:0]  pend_mask;
    logic                 alu_conflict;

    modport slave (
        input  alu_valid, alu_dest, alu_data, ld_valid, ld_dest, ld_data,
        output alu_ready, ld_ready, write_reg, read_strobe, dest_reg,
               dest_reg_data, dest_reg_data2, pend_mask, alu_conflict
    );

    modport master (
        output alu_valid, alu_dest, alu_data, ld_valid, ld_dest, ld_data,
        input  alu_ready, ld_ready, write_reg, read_strobe, dest_reg,
               dest_reg_data, dest_reg_data2, pend_mask, alu_conflict
    );

endinterface

// File: rtl/reg_wb_ctrl_wb_fifo.sv
// In-order load-result FIFO (dest + data) with per-entry valid bits that
// feed the pending-write mask.
module wb_fifo
    import reg_wb_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push_i,
    input  logic [REG_IDX_W-1:0] push_dest_i,
    input  logic [REG_W-1:0]     push_data_i,
    input  logic                 pop_i,
    output logic [REG_IDX_W-1:0] head_dest_o,
    output logic [REG_W-1:0]     head_data_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [NUM_REGS-1:0]  pend_mask_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]          wr_q, wr_d, rd_q, rd_d;
    logic [DEPTH-1:0]     vld_q, vld_d;
    logic [REG_W-1:0]     data_q [DEPTH];
    logic [REG_IDX_W-1:0] dest_q [DEPTH];
    logic                 do_push, do_pop;

    assign empty_o     = (wr_q == rd_q);
    assign full_o      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_push     = push_i && !full_o;
    assign do_pop      = pop_i && !empty_o;
    assign head_dest_o = dest_q[rd_q[AW-1:0]];
    assign head_data_o = data_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        vld_d = vld_q;
        if (do_push) begin
            vld_d[wr_q[AW-1:0]] = 1'b1;
            wr_d                = wr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            vld_d[rd_q[AW-1:0]] = 1'b0;
            rd_d                = rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            vld_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            vld_q <= vld_d;
        end
    end

    // Storage needs no reset: the valid bits and pointers gate every use.
    always_ff @(posedge clk) begin
        if (do_push) begin
            data_q[wr_q[AW-1:0]] <= push_data_i;
            dest_q[wr_q[AW-1:0]] <= push_dest_i;
        end
    end

    always_comb begin
        pend_mask_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) pend_mask_o = pend_mask_o | dec_reg(dest_q[i]);
        end
    end

endmodule

// File: rtl/reg_wb_ctrl.sv
// Arbitrates ALU and queued load results onto one registered register-file
// write per cycle, with bounded ALU priority and a pending-load hazard mask.
module reg_wb_ctrl
    import reg_wb_ctrl_pkg::*;
#(
    parameter int LD_DEPTH   = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    reg_wb_ctrl_if.slave  bus
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic                 fifo_full, fifo_empty, fifo_pop;
    logic [REG_IDX_W-1:0] head_dest;
    logic [REG_W-1:0]     head_data;
    logic [NUM_REGS-1:0]  fifo_pend, pend;
    logic                 force_ld;
    wb_src_t              win;

    logic [SW-1:0]        starve_q, starve_d;
    logic                 wr_q, wr_d, rd_q, rd_d;
    logic [REG_IDX_W-1:0] dest_q, dest_d;
    logic [REG_W-1:0]     data_q, data_d, data2_q, data2_d;
    logic                 conf_q, conf_d;

    wb_fifo #(.DEPTH(LD_DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (bus.ld_valid),
        .push_dest_i (bus.ld_dest),
        .push_data_i (bus.ld_data),
        .pop_i       (fifo_pop),
        .head_dest_o (head_dest),
        .head_data_o (head_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .pend_mask_o (fifo_pend)
    );

    assign force_ld = !fifo_empty && (starve_q == STARVE_LIM);
    assign pend     = fifo_pend | (rd_q ? dec_reg(dest_q) : '0);
    assign fifo_pop = (win == WB_LD);

    always_comb begin
        win = WB_NONE;
        if (bus.alu_valid && !force_ld) win = WB_ALU;
        else if (!fifo_empty)           win = WB_LD;
    end

    always_comb begin
        starve_d = starve_q;
        wr_d     = 1'b0;
        rd_d     = 1'b0;
        dest_d   = dest_q;
        data_d   = data_q;
        data2_d  = data2_q;
        conf_d   = conf_q;
        unique case (win)
            WB_ALU: begin
                wr_d   = 1'b1;
                dest_d = bus.alu_dest;
                data_d = bus.alu_data;
                conf_d = conf_q | pend[bus.alu_dest];
            end
            WB_LD: begin
                rd_d    = 1'b1;
                dest_d  = head_dest;
                data2_d = head_data;
            end
            default: ;
        endcase
        // The counter only measures ALU wins that kept a queued load waiting.
        if (fifo_empty || win == WB_LD)                  starve_d = '0;
        else if (win == WB_ALU && starve_q != STARVE_LIM) starve_d = starve_q + SW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_q <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            dest_q   <= '0;
            data_q   <= '0;
            data2_q  <= '0;
            conf_q   <= 1'b0;
        end else begin
            starve_q <= starve_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            dest_q   <= dest_d;
            data_q   <= data_d;
            data2_q  <= data2_d;
            conf_q   <= conf_d;
        end
    end

    assign bus.alu_ready      = !force_ld;
    assign bus.ld_ready       = !fifo_full;
    assign bus.write_reg      = wr_q;
    assign bus.read_strobe    = rd_q;
    assign bus.dest_reg       = dest_q;
    assign bus.dest_reg_data  = data_q;
    assign bus.dest_reg_data2 = data2_q;
    assign bus.pend_mask      = pend;
    assign bus.alu_conflict   = conf_q;

endmodule
